// File: rtl/seg_digit_driver_pkg.sv
// seg_digit_driver_pkg: shared constants and hex-to-segment table for the 8-digit cathode driver
package seg_digit_driver_pkg;
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam int DIGIT_COUNT = 8;
    localparam logic [2:0] SEL_LAST = 3'd7;
    localparam logic [6:0] HEX_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
endpackage

// File: rtl/seg_digit_driver_hex.sv
// hex_to_7seg: combinational nibble to active-low {g..a} segment pattern
module hex_to_7seg
    import seg_digit_driver_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    assign seg = HEX_TABLE[nibble];
endmodule

// File: rtl/seg_digit_driver.sv
// seg_digit_driver: double-buffered hex value to cathode lines with lz blanking, dp mask and blink
module seg_digit_driver
    import seg_digit_driver_pkg::*;
#(
    parameter int BLINK_DIV = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tick,
    input  logic [2:0]                 select,
    input  logic [4*DIGIT_COUNT-1:0]   value_in,
    input  logic [DIGIT_COUNT-1:0]     dp_mask,
    input  logic [DIGIT_COUNT-1:0]     blink_en,
    input  logic                       blank_lz,
    input  logic                       load,
    output logic [6:0]                 seg,
    output logic                       dp,
    output logic                       pending
);
    logic [4*DIGIT_COUNT-1:0] stg_value, act_value;
    logic [DIGIT_COUNT-1:0]   stg_dp, act_dp, stg_blink, act_blink;
    logic [7:0]               frame_cnt;
    logic                     blink_phase;
    logic                     frame_end, lz_blank, blink_blank;
    logic [6:0]               dec_seg, seg_next;
    logic                     dp_next;

    assign frame_end = tick && select == SEL_LAST;

    hex_to_7seg u_dec (
        .nibble (act_value[4*select +: 4]),
        .seg    (dec_seg)
    );

    // digit d is a leading zero when every nibble from d upward is zero
    always_comb begin
        lz_blank    = blank_lz && select != 3'd0 && (act_value >> {select, 2'b00}) == '0;
        blink_blank = act_blink[select] && blink_phase;
        seg_next    = (blink_blank || lz_blank) ? SEG_OFF : dec_seg;
        dp_next     = blink_blank ? 1'b1 : ~act_dp[select];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stg_value   <= '0;
            stg_dp      <= '0;
            stg_blink   <= '0;
            act_value   <= '0;
            act_dp      <= '0;
            act_blink   <= '0;
            pending     <= 1'b0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            seg         <= SEG_OFF;
            dp          <= 1'b1;
        end else begin
            if (load) begin
                stg_value <= value_in;
                stg_dp    <= dp_mask;
                stg_blink <= blink_en;
            end
            if (frame_end && load) begin
                act_value <= value_in;
                act_dp    <= dp_mask;
                act_blink <= blink_en;
            end else if (frame_end && pending) begin
                act_value <= stg_value;
                act_dp    <= stg_dp;
                act_blink <= stg_blink;
            end
            pending <= frame_end ? 1'b0 : (load ? 1'b1 : pending);
            if (frame_end) begin
                frame_cnt   <= (frame_cnt == 8'(BLINK_DIV - 1)) ? 8'd0 : frame_cnt + 8'd1;
                blink_phase <= blink_phase ^ (frame_cnt == 8'(BLINK_DIV - 1));
            end
            seg <= seg_next;
            dp  <= dp_next;
        end
    end
endmodule

// File: tb/tb_seg_digit_driver.sv
// tb_seg_digit_driver: directed and randomized checks against a frame-level reference model
module tb_seg_digit_driver;
    localparam int BD = 2;
    logic        clk = 1'b0;
    logic        reset, tick, load, blank_lz;
    logic [2:0]  select;
    logic [31:0] value_in;
    logic [7:0]  dp_mask, blink_en;
    logic [6:0]  seg;
    logic        dp, pending;

    logic [31:0] m_sv, m_av;
    logic [7:0]  m_sd, m_ad, m_sb, m_ab;
    logic        m_pend;
    int          frames;
    int          compared = 0;
    int          mismatched = 0;
    logic [2:0]  r_sel;
    logic [6:0]  tbl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    always #5 clk = ~clk;

    seg_digit_driver #(.BLINK_DIV(BD)) dut (
        .clk(clk), .reset(reset), .tick(tick), .select(select), .value_in(value_in),
        .dp_mask(dp_mask), .blink_en(blink_en), .blank_lz(blank_lz), .load(load),
        .seg(seg), .dp(dp), .pending(pending)
    );

    function automatic bit blinking(input logic [2:0] d);
        return m_ab[d] && ((frames / BD) % 2 == 1);
    endfunction

    function automatic logic [6:0] ref_seg(input logic [2:0] d);
        bit lz = blank_lz && d != 3'd0;
        for (int i = int'(d); i < 8; i++)
            if (m_av[4*i +: 4] != 4'd0) lz = 0;
        return (blinking(d) || lz) ? 7'h7F : tbl[m_av[4*d +: 4]];
    endfunction

    function automatic logic ref_dp(input logic [2:0] d);
        return blinking(d) ? 1'b1 : ~m_ad[d];
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        {m_sv, m_av, m_sd, m_ad, m_sb, m_ab, m_pend} = '0;
        frames = 0;
    endtask

    task automatic step(input logic tk, input logic [2:0] sel, input logic ld);
        logic [6:0] es;
        logic       ed;
        tick = tk; select = sel; load = ld;
        es = ref_seg(sel);
        ed = ref_dp(sel);
        @(posedge clk);
        if (tk && sel == 3'd7) begin
            if (ld) {m_av, m_ad, m_ab} = {value_in, dp_mask, blink_en};
            else if (m_pend) {m_av, m_ad, m_ab} = {m_sv, m_sd, m_sb};
            m_pend = 0;
            frames++;
        end else if (ld) m_pend = 1;
        if (ld) {m_sv, m_sd, m_sb} = {value_in, dp_mask, blink_en};
        #1;
        check("seg", {1'b0, seg}, {1'b0, es});
        check("dp", {7'd0, dp}, {7'd0, ed});
        check("pending", {7'd0, pending}, {7'd0, m_pend});
        tick = 0; load = 0;
    endtask

    task automatic frame();
        for (int s = 0; s < 8; s++) step(1'b1, 3'(s), 1'b0);
    endtask

    task automatic do_reset(input int cycles);
        #2 reset = 1'b1;
        #1;
        check("rst_seg", {1'b0, seg}, 8'h7F);
        check("rst_dp", {7'd0, dp}, 8'd1);
        check("rst_pend", {7'd0, pending}, 8'd0);
        repeat (cycles) begin
            @(posedge clk);
            #1;
            check("rst_hold_seg", {1'b0, seg}, 8'h7F);
            check("rst_hold_pend", {7'd0, pending}, 8'd0);
        end
        reset = 1'b0;
        model_reset();
        #1;
        check("post_rst_seg", {1'b0, seg}, 8'h7F);
        check("post_rst_dp", {7'd0, dp}, 8'd1);
    endtask

    initial begin
        reset = 0; tick = 0; load = 0; blank_lz = 0; select = 0;
        value_in = 0; dp_mask = 0; blink_en = 0;
        model_reset();
        do_reset(3);
        step(0, 3'd0, 0);
        check("first_zero", {1'b0, seg}, {1'b0, 7'b1000000});
        value_in = 32'h1234ABCD;
        step(0, 3'd3, 1);
        check("staged_pend", {7'd0, pending}, 8'd1);
        step(0, 3'd3, 0);
        check("not_torn", {1'b0, seg}, {1'b0, 7'b1000000});
        frame();
        step(0, 3'd0, 0);
        check("digit0_d", {1'b0, seg}, {1'b0, 7'b0100001});
        step(0, 3'd7, 0);
        check("digit7_1", {1'b0, seg}, {1'b0, 7'b1111001});
        value_in = 32'h00000050;
        step(0, 3'd2, 1);
        frame();
        blank_lz = 1;
        for (int s = 7; s >= 0; s--) step(0, 3'(s), 0);
        check("lz_digit0", {1'b0, seg}, {1'b0, 7'b1000000});
        blank_lz = 0;
        step(0, 3'd7, 0);
        check("no_lz_digit7", {1'b0, seg}, {1'b0, 7'b1000000});
        value_in = 32'h00000021; dp_mask = 8'h01; blink_en = 8'h01;
        step(0, 3'd4, 1);
        repeat (6) frame();
        value_in = 32'h0000000F; dp_mask = 0; blink_en = 0;
        step(1, 3'd7, 1);
        check("bypass_pend", {7'd0, pending}, 8'd0);
        step(0, 3'd0, 0);
        check("bypass_F", {1'b0, seg}, {1'b0, 7'b0001110});
        value_in = 32'hFFFFFFFF;
        step(0, 3'd2, 1);
        do_reset(1);
        for (int s = 0; s < 8; s++) begin
            step(0, 3'(s), 0);
            check("lost_stage", {1'b0, seg}, {1'b0, 7'b1000000});
        end
        r_sel = 0;
        for (int n = 0; n < 4000; n++) begin
            logic tk, ld;
            tk = ($urandom % 3) == 0;
            ld = ($urandom % 12) == 0;
            if (ld) begin
                value_in = $urandom >> ($urandom % 32);
                dp_mask  = 8'($urandom);
                blink_en = 8'($urandom) & 8'($urandom);
            end
            if (($urandom % 50) == 0) blank_lz = 1'($urandom);
            step(tk, r_sel, ld);
            if (tk) r_sel = r_sel + 3'd1;
            if (($urandom % 700) == 0) do_reset(1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
